// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box raster sequencer.
package bbox_pkg;

    localparam int COORD_W   = 16;
    localparam int FRAC_BITS = 6;
    localparam int PIX_W     = 11;
    localparam int COORDS_W  = 6 * COORD_W;

    localparam int X1_LSB = 0;
    localparam int X2_LSB = 16;
    localparam int X3_LSB = 32;
    localparam int Y1_LSB = 48;
    localparam int Y2_LSB = 64;
    localparam int Y3_LSB = 80;

    typedef enum logic [2:0] {IDLE, SORT0, SORT1, CLAMP, SCAN} state_t;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [PIX_W-1:0]   pix_t;

    typedef struct packed {
        coord_t lo;
        coord_t hi;
    } span_t;

    function automatic span_t span_merge(input span_t s, input coord_t v);
        span_t r;
        r = s;
        if (v < s.lo) r.lo = v;
        if (v > s.hi) r.hi = v;
        return r;
    endfunction

endpackage

// File: rtl/fixed_round_clamp.sv
// Purpose: Q10.6 to integer, round half up, saturate at LIMIT.
// Latency: combinational.
// Backpressure: none, pure function of its input.
module fixed_round_clamp
    import bbox_pkg::*;
#(
    parameter int LIMIT = 319
) (
    input  coord_t value,
    output pix_t   clamped
);

    pix_t rounded;

    // 11 bits so that 0xFFE0 rounds to 1024 without wrapping
    assign rounded = pix_t'(value[COORD_W-1:FRAC_BITS]) + pix_t'(value[FRAC_BITS-1]);
    assign clamped = (rounded > pix_t'(LIMIT)) ? pix_t'(LIMIT) : rounded;

endmodule

// File: rtl/bbox_raster_sequencer.sv
// Purpose: sort three vertices into a bounding box, clamp to screen, walk pixels row-major.
// Latency: first pixel presented 4 cycles after accept; one pixel per cycle thereafter.
// Backpressure: pixel outputs hold while pix_valid && !pix_ready; tri_ready low until the triangle ends.
module bbox_raster_sequencer
    import bbox_pkg::*;
#(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                tri_valid,
    output logic                tri_ready,
    input  logic [COORDS_W-1:0] coordinates,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [PIX_W-1:0]    pix_x,
    output logic [PIX_W-1:0]    pix_y,
    output logic                pix_last,
    output logic                tri_skip,
    output logic                busy
);

    state_t state;
    coord_t x2_q, x3_q, y2_q, y3_q;
    span_t  xs, ys;
    pix_t   x_lo, x_hi, y_hi;

    // Single min/max unit; the SORT state picks which vertex feeds it.
    coord_t cand_x, cand_y;
    span_t  xs_n, ys_n;

    assign cand_x = (state == SORT1) ? x3_q : x2_q;
    assign cand_y = (state == SORT1) ? y3_q : y2_q;
    assign xs_n   = span_merge(xs, cand_x);
    assign ys_n   = span_merge(ys, cand_y);

    // Min corners saturate one past the screen edge so "== limit" means off-screen.
    pix_t xmin_c, ymin_c, xmax_c, ymax_c;

    fixed_round_clamp #(.LIMIT(SCREEN_W))     u_xmin (.value(xs.lo), .clamped(xmin_c));
    fixed_round_clamp #(.LIMIT(SCREEN_H))     u_ymin (.value(ys.lo), .clamped(ymin_c));
    fixed_round_clamp #(.LIMIT(SCREEN_W - 1)) u_xmax (.value(xs.hi), .clamped(xmax_c));
    fixed_round_clamp #(.LIMIT(SCREEN_H - 1)) u_ymax (.value(ys.hi), .clamped(ymax_c));

    logic off_screen;
    assign off_screen = (xmin_c == pix_t'(SCREEN_W)) || (ymin_c == pix_t'(SCREEN_H));

    logic at_x_end, at_y_end;
    pix_t next_x, next_y;

    assign at_x_end = (pix_x == x_hi);
    assign at_y_end = (pix_y == y_hi);
    assign next_x   = at_x_end ? x_lo : pix_x + pix_t'(1);
    assign next_y   = at_x_end ? pix_y + pix_t'(1) : pix_y;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            tri_ready <= 1'b1;
            busy      <= 1'b0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_last  <= 1'b0;
            tri_skip  <= 1'b0;
            x2_q      <= '0;
            x3_q      <= '0;
            y2_q      <= '0;
            y3_q      <= '0;
            xs        <= '0;
            ys        <= '0;
            x_lo      <= '0;
            x_hi      <= '0;
            y_hi      <= '0;
        end else begin
            tri_skip <= 1'b0;
            case (state)
                IDLE: begin
                    if (tri_valid) begin
                        x2_q      <= coordinates[X2_LSB +: COORD_W];
                        x3_q      <= coordinates[X3_LSB +: COORD_W];
                        y2_q      <= coordinates[Y2_LSB +: COORD_W];
                        y3_q      <= coordinates[Y3_LSB +: COORD_W];
                        xs        <= '{lo: coordinates[X1_LSB +: COORD_W], hi: coordinates[X1_LSB +: COORD_W]};
                        ys        <= '{lo: coordinates[Y1_LSB +: COORD_W], hi: coordinates[Y1_LSB +: COORD_W]};
                        tri_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SORT0;
                    end
                end
                SORT0: begin
                    xs    <= xs_n;
                    ys    <= ys_n;
                    state <= SORT1;
                end
                SORT1: begin
                    xs    <= xs_n;
                    ys    <= ys_n;
                    state <= CLAMP;
                end
                CLAMP: begin
                    if (off_screen) begin
                        tri_skip  <= 1'b1;
                        tri_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        x_lo      <= xmin_c;
                        x_hi      <= xmax_c;
                        y_hi      <= ymax_c;
                        pix_x     <= xmin_c;
                        pix_y     <= ymin_c;
                        pix_last  <= (xmin_c == xmax_c) && (ymin_c == ymax_c);
                        pix_valid <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (pix_valid && pix_ready) begin
                        if (at_x_end && at_y_end) begin
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            tri_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            pix_x    <= next_x;
                            pix_y    <= next_y;
                            pix_last <= (next_x == x_hi) && (next_y == y_hi);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bbox_raster_sequencer.sv
// Randomized and directed bench for bbox_raster_sequencer against a pixel-list reference model.
module tb_bbox_raster_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        tri_valid;
    logic        tri_ready;
    logic [95:0] coordinates;
    logic        pix_valid;
    logic        pix_ready;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        pix_last;
    logic        tri_skip;
    logic        busy;

    bbox_raster_sequencer dut (
        .CLK(CLK), .RST(RST),
        .tri_valid(tri_valid), .tri_ready(tri_ready), .coordinates(coordinates),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
        .tri_skip(tri_skip), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        last;
    } pix_rec_t;

    int tests = 0;
    int fails = 0;

    pix_rec_t exp_q[$];
    pix_rec_t obs_q[$];
    int       exp_skip;

    int lat, skip_cnt, stab_err, busy_err, ready_end, timeout;

    function automatic int rnd_px(input int v);
        return (v / 64) + ((v / 32) % 2);
    endfunction

    // Reference: the triangle as a plain list of pixels in raster order.
    task automatic model(input int x1, x2, x3, y1, y2, y3);
        int xlo, xhi, ylo, yhi;
        xlo = x1; xhi = x1; ylo = y1; yhi = y1;
        if (x2 < xlo) xlo = x2;
        if (x3 < xlo) xlo = x3;
        if (x2 > xhi) xhi = x2;
        if (x3 > xhi) xhi = x3;
        if (y2 < ylo) ylo = y2;
        if (y3 < ylo) ylo = y3;
        if (y2 > yhi) yhi = y2;
        if (y3 > yhi) yhi = y3;
        xlo = rnd_px(xlo); xhi = rnd_px(xhi);
        ylo = rnd_px(ylo); yhi = rnd_px(yhi);
        if (xhi > 319) xhi = 319;
        if (yhi > 239) yhi = 239;
        exp_q.delete();
        exp_skip = (xlo > 319 || ylo > 239) ? 1 : 0;
        if (exp_skip == 0) begin
            for (int yy = ylo; yy <= yhi; yy++)
                for (int xx = xlo; xx <= xhi; xx++)
                    exp_q.push_back('{x: 11'(xx), y: 11'(yy), last: (xx == xhi && yy == yhi)});
        end
    endtask

    task automatic send(input int x1, x2, x3, y1, y2, y3);
        @(negedge CLK);
        coordinates = {16'(y3), 16'(y2), 16'(y1), 16'(x3), 16'(x2), 16'(x1)};
        tri_valid   = 1'b1;
        @(posedge CLK);
        #1;
        tri_valid   = 1'b0;
        coordinates = {$urandom, $urandom, $urandom};
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 3 cycles on the second pixel
    task automatic collect(input int mode, input int budget);
        int       cyc;
        bit       started, stalled, r;
        int       stall_n;
        pix_rec_t held;
        cyc = 0; started = 0; stalled = 0; stall_n = 0; held = '0;
        obs_q.delete();
        lat = -1; skip_cnt = 0; stab_err = 0; busy_err = 0; ready_end = 0; timeout = 1;
        while (cyc < budget) begin
            @(negedge CLK);
            cyc++;
            if (started && !pix_valid && !tri_skip) begin
                ready_end = tri_ready;
                if (busy !== 1'b0) busy_err++;
                if (stalled) stab_err++;
                timeout = 0;
                break;
            end
            if (!tri_skip && (busy !== 1'b1 || tri_ready !== 1'b0)) busy_err++;
            if (tri_skip) begin
                skip_cnt++;
                if (!started) lat = cyc;
                started = 1;
            end
            if (pix_valid) begin
                if (!started) lat = cyc;
                started = 1;
                if (stalled && {pix_x, pix_y, pix_last} !== held) stab_err++;
                if (mode == 0) r = 1;
                else if (mode == 1) r = ($urandom_range(0, 2) != 0);
                else if (obs_q.size() == 1 && stall_n < 3) begin r = 0; stall_n++; end
                else r = 1;
                pix_ready = r;
                held      = {pix_x, pix_y, pix_last};
                stalled   = !r;
                if (r) obs_q.push_back(held);
            end else begin
                pix_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                stalled   = 0;
            end
        end
        pix_ready = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1; tri_valid = 1'b0; pix_ready = 1'b0; coordinates = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        tests++; if (tri_ready !== 1'b1) begin fails++; $display("FAIL reset_tri_ready got %b want 1", tri_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL reset_pix_valid got %b want 0", pix_valid); end
        tests++; if (pix_x !== 11'd0 || pix_y !== 11'd0) begin fails++; $display("FAIL reset_pix_xy got (%0d,%0d) want (0,0)", pix_x, pix_y); end
        tests++; if (pix_last !== 1'b0 || tri_skip !== 1'b0) begin fails++; $display("FAIL reset_last_skip got %b%b want 00", pix_last, tri_skip); end
        RST = 1'b0;
        pix_ready = 1'b1;
    endtask

    task automatic test_basic_box();
        model(16'h0040, 16'h00C0, 16'h0080, 16'h0040, 16'h0080, 16'h0040);
        send(16'h0040, 16'h00C0, 16'h0080, 16'h0040, 16'h0080, 16'h0040);
        collect(0, 40);
        tests++; if (timeout != 0) begin fails++; $display("FAIL basic_timeout got %0d want 0", timeout); end
        tests++; if (lat != 4) begin fails++; $display("FAIL basic_latency got %0d want 4", lat); end
        tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            tests++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL basic_pixel[%0d] got %h want (%0d,%0d,last=%0d)", i,
                         (i < obs_q.size()) ? obs_q[i] : 23'h0, exp_q[i].x, exp_q[i].y, exp_q[i].last);
            end
        end
        tests++; if (ready_end != 1) begin fails++; $display("FAIL basic_ready_after got %0d want 1", ready_end); end
        tests++; if (busy_err != 0 || skip_cnt != 0) begin fails++; $display("FAIL basic_busy_skip got busy_err=%0d skip=%0d want 0,0", busy_err, skip_cnt); end
    endtask

    task automatic test_rounding();
        model(16'h0060, 16'h0060, 16'h0060, 16'h005F, 16'h005F, 16'h005F);
        send(16'h0060, 16'h0060, 16'h0060, 16'h005F, 16'h005F, 16'h005F);
        collect(0, 40);
        tests++;
        if (timeout != 0 || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            fails++;
            $display("FAIL rounding got n=%0d first=%h want one pixel (2,1,last=1)", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0] : 23'h0);
        end
        tests++; if (ready_end != 1) begin fails++; $display("FAIL rounding_ready_after got %0d want 1", ready_end); end
    endtask

    task automatic test_clamp();
        int bad;
        model(16'h0000, 16'h6400, 16'h0000, 0, 0, 0);
        send(16'h0000, 16'h6400, 16'h0000, 0, 0, 0);
        collect(0, 400);
        bad = 0;
        foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        tests++; if (obs_q.size() != 320) begin fails++; $display("FAIL clamp_count got %0d want 320", obs_q.size()); end
        tests++; if (bad != 0) begin fails++; $display("FAIL clamp_pixels got %0d wrong want 0", bad); end
        tests++;
        if (obs_q.size() == 0 || obs_q[obs_q.size()-1] !== {11'd319, 11'd0, 1'b1}) begin
            fails++; $display("FAIL clamp_last got %h want (319,0,last=1)", (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 23'h0);
        end
    endtask

    task automatic test_offscreen();
        send(16'h5000, 16'h5000, 16'h5000, 16'h0100, 16'h0200, 16'h0300);
        collect(0, 40);
        tests++; if (skip_cnt != 1) begin fails++; $display("FAIL offscreen_skip_pulses got %0d want 1", skip_cnt); end
        tests++; if (lat != 4) begin fails++; $display("FAIL offscreen_latency got %0d want 4", lat); end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL offscreen_pixels got %0d want 0", obs_q.size()); end
        tests++; if (ready_end != 1 || busy_err != 0) begin fails++; $display("FAIL offscreen_ready got ready=%0d busy_err=%0d want 1,0", ready_end, busy_err); end
    endtask

    task automatic test_backpressure();
        int bad;
        model(16'h0040, 16'h00C0, 16'h0080, 16'h0040, 16'h0080, 16'h0040);
        send(16'h0040, 16'h00C0, 16'h0080, 16'h0040, 16'h0080, 16'h0040);
        collect(2, 40);
        bad = 0;
        foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        tests++; if (stab_err != 0) begin fails++; $display("FAIL bp_stable got %0d changes want 0", stab_err); end
        tests++; if (bad != 0 || obs_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_sequence got %0d wrong n=%0d want 0 n=%0d", bad, obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid_scan();
        int n;
        send(16'h0040, 16'h00C0, 16'h0080, 16'h0040, 16'h0080, 16'h0040);
        pix_ready = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!pix_valid && n < 10);
        @(negedge CLK);
        tests++; if (pix_valid !== 1'b1 || pix_x !== 11'd2 || pix_y !== 11'd1) begin fails++; $display("FAIL rst_mid_presented got v=%b (%0d,%0d) want 1 (2,1)", pix_valid, pix_x, pix_y); end
        RST = 1'b1; pix_ready = 1'b0;
        @(posedge CLK);
        #1;
        tests++;
        if (pix_valid !== 1'b0 || pix_x !== 11'd0 || pix_y !== 11'd0 || pix_last !== 1'b0 ||
            tri_skip !== 1'b0 || tri_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_outputs got v=%b x=%0d y=%0d last=%b skip=%b rdy=%b busy=%b want 0 0 0 0 0 1 0",
                     pix_valid, pix_x, pix_y, pix_last, tri_skip, tri_ready, busy);
        end
        RST = 1'b0; pix_ready = 1'b1;
        model(16'h0040, 16'h00C0, 16'h0080, 16'h0040, 16'h0080, 16'h0040);
        send(16'h0040, 16'h00C0, 16'h0080, 16'h0040, 16'h0080, 16'h0040);
        collect(0, 40);
        tests++; if (obs_q != exp_q) begin fails++; $display("FAIL rst_mid_reaccept got n=%0d want n=%0d matching", obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_random();
        int c[6];
        int bad;
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < 6; k++) begin
                int base;
                base = (k < 3) ? ((t % 8 == 7) ? 16'hFF80 : 330 * 64) : ((t % 9 == 8) ? 16'hFF80 : 250 * 64);
                if (k % 3 == 0) c[k] = $urandom_range(0, base);
                else begin
                    c[k] = c[k - (k % 3)] + $urandom_range(0, 6 * 64);
                    if (c[k] > 16'hFFFF) c[k] = 16'hFFFF;
                end
            end
            // rotate vertex order so min/max can come from any slot
            model(c[(t+1)%3], c[(t+2)%3], c[t%3], c[3+(t+2)%3], c[3+t%3], c[3+(t+1)%3]);
            send(c[(t+1)%3], c[(t+2)%3], c[t%3], c[3+(t+2)%3], c[3+t%3], c[3+(t+1)%3]);
            collect(1, 4 * exp_q.size() + 40);
            bad = 0;
            foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
            tests++;
            if (timeout != 0 || bad != 0 || obs_q.size() != exp_q.size() || skip_cnt != exp_skip) begin
                fails++;
                $display("FAIL random[%0d] got n=%0d wrong=%0d skip=%0d to=%0d want n=%0d skip=%0d",
                         t, obs_q.size(), bad, skip_cnt, timeout, exp_q.size(), exp_skip);
            end
            tests++;
            if (lat != 4 || stab_err != 0 || busy_err != 0 || ready_end != 1) begin
                fails++;
                $display("FAIL random_ctl[%0d] got lat=%0d stab=%0d busy_err=%0d ready=%0d want 4 0 0 1",
                         t, lat, stab_err, busy_err, ready_end);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_box();
        test_rounding();
        test_clamp();
        test_offscreen();
        test_backpressure();
        test_reset_mid_scan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
